// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer FIFOs feeding a round-robin scheduled, registered common data bus.
// Optional CDB_ARBITER_PERF_EN adds perf_conflict_cnt (edges with >= 2 non-empty FIFOs).
module cdb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int ROB_WIDTH = 4,
  parameter int FIFO_DEPTH = 2,
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int TW = ROB_WIDTH + 33
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rdy_in,
  input  logic                           flush,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*ROB_WIDTH-1:0]   src_rob_id,
  input  logic [NUM_SRC*32-1:0]          src_data,
  input  logic [NUM_SRC-1:0]             src_set_jump_addr,
  output logic [NUM_SRC-1:0]             src_full,
  output logic                           cdb_rdy,
  output logic [ROB_WIDTH-1:0]           cdb_rob_id,
  output logic [31:0]                    cdb_data,
  output logic                           cdb_set_jump_addr,
  output logic [SW-1:0]                  cdb_src
`ifdef CDB_ARBITER_PERF_EN
  ,
  output logic [31:0]                    perf_conflict_cnt
`endif
);
  logic clr;
  logic any;
  logic [SW-1:0] gnt, idx, rr_q, rr_d;
  logic [NUM_SRC-1:0] nempty;
  logic [TW-1:0] head [NUM_SRC];
  logic rdy_q, sj_q;
  logic [ROB_WIDTH-1:0] rob_q;
  logic [31:0] data_q;
  logic [SW-1:0] src_q;
  assign clr = rst_in || (rdy_in && flush);
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [TW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0] cnt_q, cnt_d;
    logic push, pop;
    assign nempty[i] = cnt_q != '0;
    assign src_full[i] = cnt_q == (PW+1)'(FIFO_DEPTH);
    assign push = src_valid[i] && !src_full[i];
    assign pop = any && gnt == SW'(i);
    assign cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    assign head[i] = mem_q[rptr_q];
    always_ff @(posedge clk_in)
      if (!clr && rdy_in && push)
        mem_q[wptr_q] <= {src_rob_id[i*ROB_WIDTH +: ROB_WIDTH], src_data[i*32 +: 32], src_set_jump_addr[i]};
    always_ff @(posedge clk_in) begin
      if (clr) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q <= '0;
      end else if (rdy_in) begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop) rptr_q <= rptr_q + 1'b1;
        cnt_q <= cnt_d;
      end
    end
  end
  // Walk from the highest offset down so the closest non-empty source to rr_q wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SW'((int'(rr_q) + k) % NUM_SRC);
      if (nempty[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
    rr_d = any ? ((gnt == SW'(NUM_SRC - 1)) ? '0 : gnt + 1'b1) : rr_q;
  end
  always_ff @(posedge clk_in) begin
    if (clr) begin
      rdy_q <= 1'b0;
      rob_q <= '0;
      data_q <= '0;
      sj_q <= 1'b0;
      src_q <= '0;
      rr_q <= '0;
    end else if (rdy_in) begin
      rdy_q <= any;
      rr_q <= rr_d;
      if (any) begin
        {rob_q, data_q, sj_q} <= head[gnt];
        src_q <= gnt;
      end
    end
  end
  assign cdb_rdy = rdy_q;
  assign cdb_rob_id = rob_q;
  assign cdb_data = data_q;
  assign cdb_set_jump_addr = sj_q;
  assign cdb_src = src_q;
`ifdef CDB_ARBITER_PERF_EN
  logic [31:0] perf_q;
  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk_in) begin
    if (rst_in) perf_q <= '0;
    else if (rdy_in && $countones(nempty) >= 2) perf_q <= perf_q + 1'b1;
  end
  assign perf_conflict_cnt = perf_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of push, round-robin grant, backpressure, flush, stall and perf counter.
module tb_cdb_arbiter;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush;
  logic [2:0] src_valid, src_set_jump_addr, src_full;
  logic [11:0] src_rob_id;
  logic [95:0] src_data;
  logic cdb_rdy, cdb_set_jump_addr;
  logic [3:0] cdb_rob_id;
  logic [31:0] cdb_data;
  logic [1:0] cdb_src;
`ifdef CDB_ARBITER_PERF_EN
  logic [31:0] perf_conflict_cnt;
`endif
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk_in = ~clk_in;
  cdb_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .src_valid(src_valid), .src_rob_id(src_rob_id), .src_data(src_data),
    .src_set_jump_addr(src_set_jump_addr), .src_full(src_full),
    .cdb_rdy(cdb_rdy), .cdb_rob_id(cdb_rob_id), .cdb_data(cdb_data),
    .cdb_set_jump_addr(cdb_set_jump_addr), .cdb_src(cdb_src)
`ifdef CDB_ARBITER_PERF_EN
    , .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic put(input int i, input logic [3:0] rob, input logic [31:0] d, input logic sj);
    src_valid[i] = 1'b1;
    src_rob_id[i*4 +: 4] = rob;
    src_data[i*32 +: 32] = d;
    src_set_jump_addr[i] = sj;
  endtask
  task automatic bus(input string tag, input logic [3:0] rob, input logic [31:0] d, input logic sj, input logic [1:0] s);
    chk({tag, ".rdy"}, 64'(cdb_rdy), 64'd1);
    chk({tag, ".rob"}, 64'(cdb_rob_id), 64'(rob));
    chk({tag, ".data"}, 64'(cdb_data), 64'(d));
    chk({tag, ".sj"}, 64'(cdb_set_jump_addr), 64'(sj));
    chk({tag, ".src"}, 64'(cdb_src), 64'(s));
  endtask
  initial begin
    rst_in = 1'b1; rdy_in = 1'b0; flush = 1'b0;
    src_valid = '0; src_set_jump_addr = '0; src_rob_id = '0; src_data = '0;
    tick(); tick();
    chk("rst.rdy", 64'(cdb_rdy), 64'd0);
    chk("rst.rob", 64'(cdb_rob_id), 64'd0);
    chk("rst.data", 64'(cdb_data), 64'd0);
    chk("rst.src", 64'(cdb_src), 64'd0);
    chk("rst.full", 64'(src_full), 64'd0);
    rst_in = 1'b0; rdy_in = 1'b1;
    put(1, 4'd5, 32'hDEADBEEF, 1'b0);
    tick();
    src_valid = '0;
    chk("single.edge1", 64'(cdb_rdy), 64'd0);
    tick();
    bus("single", 4'd5, 32'hDEADBEEF, 1'b0, 2'd1);
    tick();
    chk("single.drop", 64'(cdb_rdy), 64'd0);
    chk("single.hold", 64'(cdb_rob_id), 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    put(0, 4'd1, 32'h101, 1'b0);
    put(1, 4'd2, 32'h102, 1'b0);
    put(2, 4'd3, 32'h103, 1'b1);
    tick();
    src_valid = '0;
    tick(); bus("rr0", 4'd1, 32'h101, 1'b0, 2'd0);
    tick(); bus("rr1", 4'd2, 32'h102, 1'b0, 2'd1);
    tick(); bus("rr2", 4'd3, 32'h103, 1'b1, 2'd2);
    tick(); chk("rr.idle", 64'(cdb_rdy), 64'd0);
    put(0, 4'd7, 32'h7, 1'b0); put(1, 4'd8, 32'h8, 1'b0); put(2, 4'd9, 32'h9, 1'b0);
    tick();
    src_valid = '0; put(0, 4'd10, 32'hA, 1'b0);
    tick(); bus("bp.b", 4'd7, 32'h7, 1'b0, 2'd0);
    chk("bp.full_b", 64'(src_full), 64'd0);
    put(0, 4'd11, 32'hB, 1'b0);
    tick(); bus("bp.c", 4'd8, 32'h8, 1'b0, 2'd1);
    chk("bp.full_c", 64'(src_full), 64'b001);
    put(0, 4'd12, 32'hC, 1'b0);
    tick(); bus("bp.d", 4'd9, 32'h9, 1'b0, 2'd2);
    chk("bp.full_d", 64'(src_full), 64'b001);
    src_valid = '0;
    tick(); bus("bp.e", 4'd10, 32'hA, 1'b0, 2'd0);
    chk("bp.full_e", 64'(src_full), 64'd0);
    tick(); bus("bp.f", 4'd11, 32'hB, 1'b0, 2'd0);
    tick(); chk("bp.dropped", 64'(cdb_rdy), 64'd0);
    chk("bp.hold", 64'(cdb_rob_id), 64'd11);
    put(0, 4'd1, 32'h1, 1'b0); put(2, 4'd2, 32'h2, 1'b0);
    tick();
    put(0, 4'd3, 32'h3, 1'b0); put(2, 4'd4, 32'h4, 1'b0);
    tick();
    bus("fl.pre", 4'd2, 32'h2, 1'b0, 2'd2);
    chk("fl.full_pre", 64'(src_full), 64'b001);
    src_valid = '0; put(2, 4'd5, 32'h5, 1'b0); flush = 1'b1;
    tick();
    src_valid = '0; flush = 1'b0;
    chk("fl.rdy", 64'(cdb_rdy), 64'd0);
    chk("fl.rob", 64'(cdb_rob_id), 64'd0);
    chk("fl.full", 64'(src_full), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fl.quiet", 64'(cdb_rdy), 64'd0);
    end
    put(1, 4'd6, 32'hCAFE0001, 1'b1);
    tick();
    src_valid = '0;
    chk("st.pre", 64'(cdb_rdy), 64'd0);
    rdy_in = 1'b0; put(0, 4'd13, 32'hD, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st.frozen", 64'(cdb_rdy), 64'd0);
    end
    src_valid = '0; rdy_in = 1'b1;
    tick(); bus("st.out", 4'd6, 32'hCAFE0001, 1'b1, 2'd1);
    rdy_in = 1'b0;
    tick(); chk("st.hold_rdy", 64'(cdb_rdy), 64'd1);
    rdy_in = 1'b1;
    tick(); chk("st.nopush", 64'(cdb_rdy), 64'd0);
`ifdef CDB_ARBITER_PERF_EN
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("pf.rst", 64'(perf_conflict_cnt), 64'd0);
    put(0, 4'd1, 32'h1, 1'b0); put(1, 4'd2, 32'h2, 1'b0);
    tick();
    src_valid = '0;
    chk("pf.push", 64'(perf_conflict_cnt), 64'd0);
    tick(); chk("pf.one", 64'(perf_conflict_cnt), 64'd1);
    tick(); chk("pf.still", 64'(perf_conflict_cnt), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("pf.flush", 64'(perf_conflict_cnt), 64'd1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
